// File: rtl/intt_ctrl_pkg.sv
// Shared types and address helper for the NTT/INTT stage sequencers.
package intt_ctrl_pkg;

  localparam int unsigned MAX_LOG_N   = 12;
  localparam int unsigned DEFAULT_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Butterfly address triple; tw is left-aligned in MAX_LOG_N-1 bits so a
  // caller with a smaller transform takes it shifted right by MAX_LOG_N-LOG_N.
  typedef struct packed {
    logic [MAX_LOG_N-1:0] a;
    logic [MAX_LOG_N-1:0] b;
    logic [MAX_LOG_N-2:0] tw;
  } bf_addr_t;

  // Pair (a, b) and twiddle index for issue count k in stage s (span h = 1<<s).
  function automatic bf_addr_t bf_addr(input logic [MAX_LOG_N-1:0] k,
                                       input logic [MAX_LOG_N-1:0] s);
    bf_addr_t             r;
    logic [MAX_LOG_N-1:0] h;
    logic [MAX_LOG_N-1:0] lo;
    h    = MAX_LOG_N'(1) << s;
    lo   = k & (h - MAX_LOG_N'(1));
    r.a  = ((k >> s) << (s + MAX_LOG_N'(1))) | lo;
    r.b  = r.a | h;
    r.tw = (MAX_LOG_N-1)'(lo << (MAX_LOG_N'(MAX_LOG_N - 1) - s));
    return r;
  endfunction

endpackage

// File: rtl/intt_wb_delay.sv
// Fixed-depth delay line turning issued read strobes/addresses into write-backs.
module intt_wb_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift every cycle; reset drops anything still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/intt_stage_ctrl.sv
// Gentleman-Sande INTT stage sequencer: issues butterfly pairs, delays them
// into write-backs and drains the pipe between stages.
module intt_stage_ctrl
  import intt_ctrl_pkg::*;
#(
  parameter int unsigned LOG_N = 4,
  parameter int unsigned LAT   = DEFAULT_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG_N-1:0] stage,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int unsigned KW   = LOG_N - 1;
  localparam int unsigned DW   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned WB_W = 1 + 2 * LOG_N;

  localparam logic [KW-1:0]    K_LAST   = '1;
  localparam logic [LOG_N-1:0] S_LAST   = LOG_N'(LOG_N - 1);
  localparam logic [DW-1:0]    DRN_LOAD = DW'(LAT - 1);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [LOG_N-1:0] s_q, s_d;
  logic [DW-1:0]    drn_q, drn_d;

  bf_addr_t         bf;
  logic             issue;
  logic [WB_W-1:0]  wb_in;
  logic [WB_W-1:0]  wb_out;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      drn_q   <= drn_d;
    end
  end

  // Next state: N/2 issue cycles, LAT drain cycles per stage, one DONE cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    drn_d   = drn_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          k_d     = '0;
          s_d     = '0;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
          drn_d   = DRN_LOAD;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (drn_q == '0) begin
          if (s_q != S_LAST) begin
            s_d     = s_q + LOG_N'(1);
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          drn_d = drn_q - DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and counters; addresses read zero when not issuing.
  always_comb begin
    bf        = bf_addr(MAX_LOG_N'(k_q), MAX_LOG_N'(s_q));
    issue     = (state_q == ISSUE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    stage     = s_q;
    rd_en     = issue;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_addr   = '0;
    if (issue) begin
      rd_addr_a = LOG_N'(bf.a);
      rd_addr_b = LOG_N'(bf.b);
      tw_addr   = KW'(bf.tw >> (MAX_LOG_N - LOG_N));
    end
  end

  assign wb_in = {rd_en, rd_addr_a, rd_addr_b};

  intt_wb_delay #(
    .DEPTH(LAT),
    .WIDTH(WB_W)
  ) u_wb_delay (
    .clk  (clk),
    .reset(reset),
    .d_i  (wb_in),
    .q_o  (wb_out)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = wb_out;

endmodule

// File: tb/tb_intt_stage_ctrl.sv
// Scoreboard bench for intt_stage_ctrl (LOG_N=3, LAT=2).
module tb_intt_stage_ctrl;

  localparam int LOG_N = 3;
  localparam int LAT   = 2;
  localparam int N     = 1 << LOG_N;
  localparam int HALF  = N / 2;
  localparam int T     = LOG_N * (HALF + LAT) + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int st;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy, done, rd_en, wr_en;
  logic [LOG_N-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG_N-2:0] tw_addr;

  ev_t rdq[$];
  ev_t wrq[$];
  int  doneq[$];
  int  busy_lo = 1;
  int  busy_hi = 0;
  int  cyc     = 0;
  int  nvec    = 0;
  int  nfail   = 0;
  bit  pend [N];

  intt_stage_ctrl #(.LOG_N(LOG_N), .LAT(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference: stage s pairs words i and i+h inside each block of 2h words,
  // blocks in ascending order; twiddle index steps by N/(2h).
  task automatic push_model(input int c0);
    for (int s = 0; s < LOG_N; s++) begin
      int h;
      h = 1 << s;
      for (int j = 0; j < N / (2 * h); j++) begin
        for (int i = 0; i < h; i++) begin
          ev_t e;
          e.cyc = c0 + 1 + s * (HALF + LAT) + j * h + i;
          e.a   = j * 2 * h + i;
          e.b   = e.a + h;
          e.tw  = i * (N / (2 * h));
          e.st  = s;
          rdq.push_back(e);
          e.cyc = e.cyc + LAT;
          wrq.push_back(e);
        end
      end
    end
    doneq.push_back(c0 + T);
    busy_lo = c0 + 1;
    busy_hi = c0 + T;
  endtask

  task automatic start_xfer();
    start = 1'b1;
    push_model(cyc);
  endtask

  task automatic apply_reset(input int hold);
    reset = 1'b1;
    start = 1'b0;
    rdq.delete();
    wrq.delete();
    doneq.delete();
    busy_lo = 1;
    busy_hi = 0;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        check("reset_outs", int'({busy, done, stage, rd_en, rd_addr_a, rd_addr_b,
                                  tw_addr, wr_en, wr_addr_a, wr_addr_b}), 0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
      end else begin
        check("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        while (rdq.size() > 0 && rdq[0].cyc < cyc) begin
          e = rdq.pop_front();
          nvec++; nfail++;
          $display("FAIL rd_missed cyc=%0d got=none expected_cycle=%0d a=%0d", cyc, e.cyc, e.a);
        end
        while (wrq.size() > 0 && wrq[0].cyc < cyc) begin
          e = wrq.pop_front();
          nvec++; nfail++;
          $display("FAIL wr_missed cyc=%0d got=none expected_cycle=%0d a=%0d", cyc, e.cyc, e.a);
        end
        while (doneq.size() > 0 && doneq[0] < cyc) begin
          nvec++; nfail++;
          $display("FAIL done_missed cyc=%0d got=none expected_cycle=%0d", cyc, doneq.pop_front());
        end
        if (rd_en) begin
          check("hazard_a", int'(pend[rd_addr_a]), 0);
          check("hazard_b", int'(pend[rd_addr_b]), 0);
          if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
            e = rdq.pop_front();
            check("rd_a", int'(rd_addr_a), e.a);
            check("rd_b", int'(rd_addr_b), e.b);
            check("tw", int'(tw_addr), e.tw);
            check("stage", int'(stage), e.st);
          end else begin
            nvec++; nfail++;
            $display("FAIL rd_unexpected cyc=%0d got a=%0d b=%0d expected=no read", cyc, rd_addr_a, rd_addr_b);
          end
        end
        if (wr_en) begin
          if (wrq.size() > 0 && wrq[0].cyc == cyc) begin
            e = wrq.pop_front();
            check("wr_a", int'(wr_addr_a), e.a);
            check("wr_b", int'(wr_addr_b), e.b);
          end else begin
            nvec++; nfail++;
            $display("FAIL wr_unexpected cyc=%0d got a=%0d b=%0d expected=no write", cyc, wr_addr_a, wr_addr_b);
          end
          pend[wr_addr_a] = 1'b0;
          pend[wr_addr_b] = 1'b0;
        end
        if (rd_en) begin
          pend[rd_addr_a] = 1'b1;
          pend[rd_addr_b] = 1'b1;
        end
        if (done) begin
          if (doneq.size() > 0 && doneq[0] == cyc) begin
            check("done_cycle", cyc, doneq.pop_front());
          end else begin
            nvec++; nfail++;
            $display("FAIL done_unexpected cyc=%0d got=1 expected=0", cyc);
          end
        end
      end
    end
  end

  // Stimulus: directed back-to-back and mid-run reset, then randomized runs.
  initial begin
    int mode, ra, hold;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // start held high: second transform starts from the first IDLE after DONE
    start_xfer();
    repeat (T + 1) @(negedge clk);
    push_model(cyc);
    @(negedge clk);
    start = 1'b0;
    repeat (T) @(negedge clk);

    // reset in cycle 8, restart in cycle 12
    @(negedge clk);
    start_xfer();
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    apply_reset(2);
    repeat (2) @(negedge clk);
    start_xfer();
    @(negedge clk);
    start = 1'b0;
    repeat (T) @(negedge clk);

    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      start_xfer();
      mode = int'($urandom_range(0, 3));
      case (mode)
        0, 1: begin
          for (int t = 1; t <= T; t++) begin
            @(negedge clk);
            start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          end
          @(negedge clk);
          start = 1'b0;
        end
        2: begin
          repeat (T + 1) @(negedge clk);
          push_model(cyc);
          @(negedge clk);
          start = 1'b0;
          repeat (T) @(negedge clk);
        end
        default: begin
          ra   = int'($urandom_range(1, T));
          hold = int'($urandom_range(1, 3));
          @(negedge clk);
          start = 1'b0;
          repeat (ra - 1) @(negedge clk);
          apply_reset(hold);
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      endcase
    end

    repeat (LAT + 3) @(negedge clk);
    #4;
    check("rd_pending_at_end", rdq.size(), 0);
    check("wr_pending_at_end", wrq.size(), 0);
    check("done_pending_at_end", doneq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/intt_stage_ctrl.md
# intt_stage_ctrl

Sequencer for the INTT butterfly core. On `start` it walks all `LOG_N` Gentleman–Sande stages over an N-point coefficient memory. Each cycle it issues one butterfly pair of read addresses plus a twiddle-ROM address. It delays the pair by the read+core pipeline latency to produce write-back addresses, and drains the pipeline between stages so that no stage reads a word its predecessor has not yet written. The block sits between the coefficient RAM / twiddle ROM and the butterfly core, and contains no arithmetic datapath.

## Interface
Parameters:
- `LOG_N`, default 4: log2 of transform size N; legal range 2..12.
- `LAT`, default 2: cycles from `rd_en` to the matching `wr_en` (1 RAM read + 1 core register); legal range ≥1.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: request a transform; sampled only in IDLE.
- `busy` out 1: high from the first ISSUE cycle through the DONE cycle.
- `done` out 1: one-cycle pulse after the final write-back.
- `stage` out LOG_N: current stage index s.
- `rd_en` out 1: butterfly issue strobe.
- `rd_addr_a`, `rd_addr_b` out LOG_N: operand addresses a and b.
- `tw_addr` out LOG_N-1: twiddle ROM index for the issued pair.
- `wr_en` out 1: write-back strobe, equal to `rd_en` delayed by `LAT` cycles.
- `wr_addr_a`, `wr_addr_b` out LOG_N: the issued addresses, delayed by `LAT` cycles.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE when `start` is 1. This clears issue counter k and stage s, and the `start` level is ignored in every other state.
- ISSUE: `rd_en`=1 every cycle while k runs 0..N/2-1. At k=N/2-1 the FSM goes to DRAIN, clears k and loads the drain counter with LAT-1.
- DRAIN: `rd_en`=0 for exactly `LAT` cycles. When it ends:
  - if s<LOG_N-1: s increments and the FSM returns to ISSUE;
  - otherwise the FSM goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Address generation, with h = 1<<s:
  - a = ((k>>s)<<(s+1)) | (k & (h-1));
  - b = a | h;
  - `tw_addr` = (k & (h-1)) << (LOG_N-1-s).
- All address arithmetic is unsigned, `LOG_N` bits wide, with no wrap. a<b always holds.
- Write-back pipeline: a `LAT`-deep shift register of {rd_en, rd_addr_a, rd_addr_b}. It keeps shifting in every state, including IDLE and DONE.
- Reset, including mid-transform:
  - state returns to IDLE; k, s and the drain counter go to 0;
  - the delay line is cleared, so no pending write is emitted;
  - all outputs read 0, including `wr_en`.
- Scaling by N⁻¹ is outside this block.

## Timing
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled in IDLE. ISSUE begins in cycle 1.
- Each stage occupies N/2 + LAT cycles.
- `done` is high in cycle LOG_N·(N/2+LAT)+1. `busy` is high in cycles 1 through that cycle.
- A `start` that is high in the DONE cycle is ignored. The earliest restart is `start` in the first IDLE cycle after DONE.
- Write ordering:
  - the last write of stage s lands in the last DRAIN cycle;
  - the first read of stage s+1 occurs the next cycle.
- All outputs are driven from registers, combinational from state/counters, or from the delay line. No output depends combinationally on `start`.

## Structure
- Shared package `intt_ctrl_pkg` holds:
  - the state enum {IDLE, ISSUE, DRAIN, DONE};
  - a function `bf_addr(k, s)` returning {a, b, tw}, reused by the NTT-direction controller;
  - a default `LAT` constant.
- One sub-module, `intt_wb_delay`, parameterised by depth and width, with an async-reset shift register.

## Test plan
All scenarios use LOG_N=3, LAT=2.
- Reset values: hold `reset` 3 cycles → all outputs 0 and state IDLE. Pulse `start` → `busy` rises in cycle 1.
- Stage 0 addressing: `start` → cycles 1–4 show (a,b,tw) = (0,1,0), (2,3,0), (4,5,0), (6,7,0). `wr_en` is high in cycles 3–6 with the same addresses.
- Stage 1 and stage 2 addressing:
  - stage 1, cycles 7–10: (0,2,0), (1,3,2), (4,6,0), (5,7,2);
  - stage 2, cycles 13–16: (0,4,0), (1,5,1), (2,6,2), (3,7,3).
- Completion: `done` pulses only in cycle 19; `busy` deasserts in cycle 20. `start` held high throughout → next ISSUE begins in cycle 21.
- Hazard check: a RAM model flags any read of an address whose write is still pending → zero flags over a full transform.
- Mid-run reset: assert `reset` in cycle 8 → `rd_en` and `wr_en` are 0 immediately and stay 0, with no stray write after release. `start` in cycle 12 → stage 0 sequence resumes from (0,1,0).
